// File: rtl/pcileech_board_pkg.sv
// Shared types for the PCILeech board-control block: reset FSM states, LED modes
// and the LED mode decoder.
package pcileech_board_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_BTN  = 2'd2
  } rst_state_t;

  typedef enum logic [1:0] {
    LED_OFF = 2'b00,
    LED_ON  = 2'b01,
    LED_SRC = 2'b10,
    LED_INV = 2'b11
  } led_mode_t;

  function automatic logic led_decode(input led_mode_t mode, input logic src);
    case (mode)
      LED_OFF: return 1'b0;
      LED_ON:  return 1'b1;
      LED_SRC: return src;
      default: return ~src;
    endcase
  endfunction

endpackage

// File: rtl/pcileech_board_ctl_if.sv
// Pad-side bundle of the board-control block: buttons, LEDs, reset/reload
// strobes, debounced button status and the tick counter.
interface pcileech_board_ctl_if #(
  parameter int unsigned NUM_BTN = 2,
  parameter int unsigned NUM_LED = 2
);
  logic [NUM_BTN-1:0]   btn_n;
  logic [NUM_LED-1:0]   led_src;
  logic [2*NUM_LED-1:0] led_mode;
  logic [NUM_LED-1:0]   led_n;
  logic                 sys_rst;
  logic                 cfg_reload;
  logic [NUM_BTN-1:0]   btn_state;
  logic [NUM_BTN-1:0]   btn_press;
  logic [63:0]          tickcount;

  modport master (
    output btn_n, led_src, led_mode,
    input  led_n, sys_rst, cfg_reload, btn_state, btn_press, tickcount
  );

  modport slave (
    input  btn_n, led_src, led_mode,
    output led_n, sys_rst, cfg_reload, btn_state, btn_press, tickcount
  );
endinterface

// File: rtl/pcileech_debounce.sv
// One button: 2-FF synchroniser, stable-count debounce and press-edge pulse.
// btn_state is 1 while the button is (debounced) pressed.
module pcileech_debounce #(
  parameter int unsigned PARAM_DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_state,
  output logic btn_press
);

  localparam int unsigned      CNT_W    = $clog2(PARAM_DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARAM_DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  assign pressed = ~sync_p1;

  // stage boundary: synchroniser -> debounce counter / state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      cnt       <= '0;
      btn_state <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync_p0   <= btn_n;
      sync_p1   <= sync_p0;
      btn_press <= 1'b0;
      if (pressed == btn_state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        btn_state <= pressed;
        btn_press <= pressed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pcileech_board_ctl.sv
// Board control for PCILeech tops: button debounce, system reset sequencing,
// long-press config reload, 64-bit tick counter and LED drive with power-on blink.
module pcileech_board_ctl
  import pcileech_board_pkg::*;
#(
  parameter int unsigned PARAM_NUM_BTN          = 2,
  parameter int unsigned PARAM_NUM_LED          = 2,
  parameter int unsigned PARAM_DEBOUNCE_CYC     = 1000000,
  parameter int unsigned PARAM_RST_HOLD_CYC     = 64,
  parameter int unsigned PARAM_RELOAD_CYC       = 500000000,
  parameter int unsigned PARAM_RST_BTN          = 1,
  parameter int unsigned PARAM_RELOAD_BTN       = 1,
  parameter int unsigned PARAM_BLINK_BIT        = 24,
  parameter int unsigned PARAM_BLINK_WINDOW_BIT = 27,
  parameter logic [7:0]  PARAM_BLINK_MASK       = 8'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcileech_board_ctl_if.slave  bus
);

  localparam int unsigned       HOLD_W      = $clog2(PARAM_RST_HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(PARAM_RST_HOLD_CYC - 1);
  localparam logic [31:0]       RELOAD_LAST = 32'(PARAM_RELOAD_CYC - 1);

  logic [PARAM_NUM_BTN-1:0] btn_state_w;
  logic [PARAM_NUM_BTN-1:0] btn_press_w;
  logic                     rst_btn;
  logic                     rl_btn;

  rst_state_t               state;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     sys_rst_p0;
  logic                     enter_btn;
  logic [63:0]              tick_p0;

  logic [31:0]              rl_cnt;
  logic                     cfg_reload_p0;

  logic                     blink;
  logic [PARAM_NUM_LED-1:0] led_next;
  logic [PARAM_NUM_LED-1:0] led_n_p0;

  for (genvar i = 0; i < PARAM_NUM_BTN; i++) begin : g_btn
    pcileech_debounce #(
      .PARAM_DEBOUNCE_CYC(PARAM_DEBOUNCE_CYC)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_n     (bus.btn_n[i]),
      .btn_state (btn_state_w[i]),
      .btn_press (btn_press_w[i])
    );
  end

  assign rst_btn   = btn_state_w[PARAM_RST_BTN];
  assign rl_btn    = btn_state_w[PARAM_RELOAD_BTN];
  assign enter_btn = (state == ST_RUN) && rst_btn;

  // stage boundary: debounced buttons -> reset FSM
  // The BTN cycle that observes the release is the first hold cycle, so the
  // hold count restarts at 1 and HOLD exits on >= rather than ==.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      sys_rst_p0 <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          sys_rst_p0 <= 1'b1;
          if (hold_cnt >= HOLD_LAST) begin
            state      <= ST_RUN;
            hold_cnt   <= '0;
            sys_rst_p0 <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          hold_cnt   <= '0;
          sys_rst_p0 <= 1'b0;
          if (rst_btn) begin
            state      <= ST_BTN;
            sys_rst_p0 <= 1'b1;
          end
        end
        ST_BTN: begin
          hold_cnt   <= '0;
          sys_rst_p0 <= 1'b1;
          if (!rst_btn) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_W'(1);
          end
        end
        default: begin
          state      <= ST_HOLD;
          hold_cnt   <= '0;
          sys_rst_p0 <= 1'b1;
        end
      endcase
    end
  end

  // Cleared on the RUN->BTN edge too, so the counter already reads 0 in the first BTN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || state == ST_BTN || enter_btn) begin
      tick_p0 <= '0;
    end else begin
      tick_p0 <= tick_p0 + 64'd1;
    end
  end

  // stage boundary: debounced reload button -> saturating hold counter / pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rl_cnt        <= '0;
      cfg_reload_p0 <= 1'b0;
    end else begin
      if (!rl_btn) begin
        rl_cnt <= '0;
      end else if (rl_cnt != '1) begin
        rl_cnt <= rl_cnt + 32'd1;
      end
      cfg_reload_p0 <= rl_btn && (rl_cnt == RELOAD_LAST);
    end
  end

  assign blink = tick_p0[PARAM_BLINK_BIT] & ~|tick_p0[63:PARAM_BLINK_WINDOW_BIT];

  always_comb begin
    led_next = '1;
    for (int i = 0; i < PARAM_NUM_LED; i++) begin
      led_next[i] = ~(led_decode(led_mode_t'(bus.led_mode[2*i +: 2]), bus.led_src[i])
                      ^ (blink & PARAM_BLINK_MASK[i]));
    end
  end

  // stage boundary: LED decode -> pads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_n_p0 <= '1;
    end else begin
      led_n_p0 <= led_next;
    end
  end

  assign bus.sys_rst    = sys_rst_p0;
  assign bus.cfg_reload = cfg_reload_p0;
  assign bus.btn_state  = btn_state_w;
  assign bus.btn_press  = btn_press_w;
  assign bus.tickcount  = tick_p0;
  assign bus.led_n      = led_n_p0;

endmodule

// File: doc/pcileech_board_ctl.md
# pcileech_board_ctl

Parametrised board-control block for PCILeech FPGA tops. It synchronises and debounces N user buttons, generates the system reset from power-on and button hold, and emits a single-cycle config-reload pulse after a long press. It also runs the 64-bit tick counter and drives M active-low LEDs with per-LED mode, including the power-on blink. It sits in each board top between the pads and pcileech_com / pcileech_fifo / pcileech_pcie_*, and replaces the ad-hoc per-board tickcount/reset/LED logic.

## Interface
- PARAM_NUM_BTN, 2: number of active-low button inputs (1..8).
- PARAM_NUM_LED, 2: number of active-low LED outputs (1..8).
- PARAM_DEBOUNCE_CYC, 1000000: consecutive stable cycles before a button change is accepted (≥2).
- PARAM_RST_HOLD_CYC, 64: cycles sys_rst stays asserted after any reset source releases (≥1).
- PARAM_RELOAD_CYC, 500000000: debounced hold cycles of the reload button before cfg_reload fires.
- PARAM_RST_BTN, 1: button index that forces reset while held.
- PARAM_RELOAD_BTN, 1: button index timed for reload (may equal PARAM_RST_BTN).
- PARAM_BLINK_BIT, 24: tickcount bit driving power-on blink.
- PARAM_BLINK_WINDOW_BIT, 27: blink active while tickcount[63:this] == 0.
- PARAM_BLINK_MASK, 'b01: LEDs subject to the power-on blink XOR.
- clk  in  1  system clock; only clock.
- rst_n  in  1  synchronous active-low reset (power-on / external).
- btn_n  in  NUM_BTN  raw asynchronous buttons, active-low.
- led_src  in  NUM_LED  activity sources (e.g. led_pcie, led_com), active-high.
- led_mode  in  2*NUM_LED  per-LED mode: 00 off, 01 on, 10 follow led_src, 11 led_src inverted.
- led_n  out  NUM_LED  LED pads, active-low.
- sys_rst  out  1  active-high system reset to downstream blocks.
- cfg_reload  out  1  single-cycle reload pulse.
- btn_state  out  NUM_BTN  debounced button level, 1 = pressed.
- btn_press  out  NUM_BTN  single-cycle pulse on debounced press edge.
- tickcount  out  64  free-running tick counter.

## Operation
- Sync: btn_n passes through a 2-FF synchroniser, then is inverted to pressed = 1.
- Debounce, per button: counter cleared whenever the sampled value equals btn_state. While the values differ, the counter increments. On reaching PARAM_DEBOUNCE_CYC-1 while still differing, btn_state toggles and the counter clears. btn_press fires on the 0→1 toggle only.
- Reset FSM states:
  - HOLD: sys_rst=1, hold counter counts up; → RUN when it reaches PARAM_RST_HOLD_CYC-1.
  - RUN: sys_rst=0; → BTN when btn_state[PARAM_RST_BTN] = 1.
  - BTN: sys_rst=1, hold counter cleared; → HOLD on release.
  - rst_n low forces HOLD from any state with the counter cleared.
- tickcount: 0 while rst_n low or in BTN; otherwise increments by 1 every cycle, wrapping 2^64-1 → 0.
- Reload: a 32-bit saturating hold counter increments while btn_state[PARAM_RELOAD_BTN] = 1 and clears on release. cfg_reload pulses exactly once, in the cycle the counter equals PARAM_RELOAD_CYC. It cannot re-fire until release. The pulse is generated in any FSM state, including BTN.
- LEDs: base = decode(led_mode, led_src). blink = tickcount[BLINK_BIT] & (tickcount[63:BLINK_WINDOW_BIT]==0), applied to BLINK_MASK LEDs by XOR. led_n = ~(base ^ blink_masked).

## Timing
- Reset values (rst_n low at clk edge): sys_rst=1, cfg_reload=0, btn_state=0, btn_press=0, tickcount=0, led_n all 1, FSM=HOLD.
- Press-to-btn_state latency: 2 sync cycles + PARAM_DEBOUNCE_CYC cycles. Bounces shorter than that are filtered.
- sys_rst deasserts exactly PARAM_RST_HOLD_CYC cycles after rst_n rises, or after the debounced release of the reset button.
- rst_n is sampled in the same cycle as a button event: rst_n wins.
- led_n is registered, 1 cycle after led_src/led_mode/tickcount.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- pcileech_board_pkg holds the FSM state enum (HOLD, RUN, BTN) and the LED mode enum (OFF, ON, SRC, INV).
- Sub-module pcileech_debounce (sync + debounce + press pulse, one button) is instantiated PARAM_NUM_BTN times via generate.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, RST_HOLD_CYC=8, RELOAD_CYC=20, BLINK_BIT=2, BLINK_WINDOW_BIT=4.
- Power-on: rst_n low 3 cycles then high → sys_rst=1 for exactly 8 cycles, then 0; tickcount=0 at release, 8 when sys_rst falls.
- Bounce: btn_n[0] toggled low/high every 2 cycles for 20 cycles, then held low → btn_state[0] stays 0 during bounce; goes 1 exactly 6 cycles after the final low; btn_press[0] pulses once.
- Reset button: hold btn_n[1] low 30 cycles → sys_rst=1 and tickcount=0 while held. After the debounced release, sys_rst stays high 8 more cycles; tickcount restarts from 0.
- Reload: hold btn_n[1] low 60 cycles → cfg_reload high for exactly one cycle, 20 cycles after btn_state[1] rises; no second pulse. Release and re-press repeats it.
- LEDs: led_mode='b10_01, led_src='b00 → led_n[1] (mode 10, follows led_src) = 1 (off). led_n[0] (mode 01) is on and toggles every 4 cycles while tickcount<16, then stays at 0 (lit).
- Mid-operation reset: rst_n pulsed low during the reload hold → counters clear, no cfg_reload pulse, sys_rst=1 for 8 cycles after rst_n rises.
